servo_sequencer: RTL and testbench



---
 rtl/servo_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_servo_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_sequencer.sv
// Hobby-servo PWM sequencer: 50 Hz frame, manual position hold or automatic 1..5..1 sweep,
// with pulse-width changes slew-limited and applied only at frame boundaries.
module servo_sequencer #(
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned PW_MIN       = 50000,
  parameter int unsigned PW_STEP      = 12500,
  parameter int unsigned SLEW         = 2500,
  parameter int unsigned DWELL_FRAMES = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_modo,
  input  logic [4:0] pos_sel,
  output logic       pwm,
  output logic       frame_tick,
  output logic       busy,
  output logic [4:0] at_pos
);

  localparam int unsigned FCNT_W  = 20;
  localparam int unsigned PW_W    = 17;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned DWELL_W = (DWELL_FRAMES < 1) ? 1 : $clog2(DWELL_FRAMES + 1);

  localparam logic [FCNT_W-1:0]  FCNT_LAST = FCNT_W'(FRAME_CYCLES - 1);
  localparam logic [FCNT_W-1:0]  FCNT_PRE  = FCNT_W'(FRAME_CYCLES - 2);
  localparam logic [PW_W-1:0]    SLEW_PW   = PW_W'(SLEW);
  localparam logic [PW_W-1:0]    PW_CENTER = PW_W'(PW_MIN + 2 * PW_STEP);
  localparam logic [DWELL_W-1:0] DWELL_END = DWELL_W'(DWELL_FRAMES);
  localparam logic [IDX_W-1:0]   IDX_1     = IDX_W'(1);
  localparam logic [IDX_W-1:0]   IDX_3     = IDX_W'(3);
  localparam logic [IDX_W-1:0]   IDX_5     = IDX_W'(5);

  typedef enum logic [1:0] {
    MANUAL     = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic               sel_meta, sel_sync;
  logic [4:0]         pos_meta, pos_sync;
  logic [FCNT_W-1:0]  fcnt, fcnt_nxt;
  logic               boundary;
  logic [IDX_W-1:0]   tgt_idx, tgt_nxt, manual_idx;
  logic [DWELL_W-1:0] dwell, dwell_nxt, dwell_inc;
  logic [PW_W-1:0]    pw_cur, pw_nxt, pw_tgt_nxt, pw_diff;
  logic [4:0]         at_pos_nxt;

  function automatic logic [PW_W-1:0] pw_of(input logic [IDX_W-1:0] idx);
    pw_of = PW_W'(PW_MIN + (32'(idx) - 32'd1) * PW_STEP);
  endfunction

  // Two-flop synchronisers for the UART-domain command lines
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
      pos_meta <= '0;
      pos_sync <= '0;
    end else begin
      sel_meta <= sel_modo;
      sel_sync <= sel_meta;
      pos_meta <= pos_sel;
      pos_sync <= pos_meta;
    end
  end

  assign fcnt_nxt = (fcnt == FCNT_LAST) ? '0 : fcnt + FCNT_W'(1);
  assign boundary = (fcnt == FCNT_LAST);

  // Frame counter and PWM output stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      fcnt       <= '0;
      pwm        <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      fcnt       <= fcnt_nxt;
      pwm        <= (fcnt < FCNT_W'(pw_cur));
      frame_tick <= (fcnt == FCNT_PRE);
    end
  end

  // Manual-mode target: only a clean one-hot command moves it
  always_comb begin
    manual_idx = tgt_idx;
    case (pos_sync)
      5'b00001: manual_idx = IDX_W'(1);
      5'b00010: manual_idx = IDX_W'(2);
      5'b00100: manual_idx = IDX_W'(3);
      5'b01000: manual_idx = IDX_W'(4);
      5'b10000: manual_idx = IDX_W'(5);
      default:  manual_idx = tgt_idx;
    endcase
  end

  // Boundary update: mode/target first, then the slew-limited ramp toward the new target
  always_comb begin
    state_nxt  = state;
    tgt_nxt    = tgt_idx;
    dwell_nxt  = dwell;
    dwell_inc  = dwell + DWELL_W'(1);
    pw_nxt     = pw_cur;
    pw_diff    = '0;
    pw_tgt_nxt = pw_of(tgt_idx);
    at_pos_nxt = '0;

    if (boundary) begin
      case (state)
        MANUAL: begin
          if (sel_sync) begin
            state_nxt = (tgt_idx == IDX_5) ? SWEEP_DOWN : SWEEP_UP;
            dwell_nxt = '0;
          end else begin
            tgt_nxt = manual_idx;
          end
        end
        SWEEP_UP, SWEEP_DOWN: begin
          if (!sel_sync) begin
            state_nxt = MANUAL;
            dwell_nxt = '0;
            tgt_nxt   = manual_idx;
          end else if (!busy) begin
            if (dwell_inc >= DWELL_END) begin
              dwell_nxt = '0;
              if (state == SWEEP_UP) begin
                if (tgt_idx == IDX_5) begin
                  state_nxt = SWEEP_DOWN;
                  tgt_nxt   = tgt_idx - IDX_W'(1);
                end else begin
                  tgt_nxt = tgt_idx + IDX_W'(1);
                end
              end else begin
                if (tgt_idx == IDX_1) begin
                  state_nxt = SWEEP_UP;
                  tgt_nxt   = tgt_idx + IDX_W'(1);
                end else begin
                  tgt_nxt = tgt_idx - IDX_W'(1);
                end
              end
            end else begin
              dwell_nxt = dwell_inc;
            end
          end
        end
        default: begin
          state_nxt = MANUAL;
          dwell_nxt = '0;
        end
      endcase

      pw_tgt_nxt = pw_of(tgt_nxt);
      // Subtract only in the direction that cannot wrap
      if (pw_cur >= pw_tgt_nxt) begin
        pw_diff = pw_cur - pw_tgt_nxt;
        pw_nxt  = (pw_diff <= SLEW_PW) ? pw_tgt_nxt : pw_cur - SLEW_PW;
      end else begin
        pw_diff = pw_tgt_nxt - pw_cur;
        pw_nxt  = (pw_diff <= SLEW_PW) ? pw_tgt_nxt : pw_cur + SLEW_PW;
      end
    end

    for (int k = 0; k < 5; k++) begin
      at_pos_nxt[k] = (pw_nxt == pw_of(IDX_W'(k + 1)));
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= MANUAL;
      tgt_idx <= IDX_3;
      dwell   <= '0;
      pw_cur  <= PW_CENTER;
      busy    <= 1'b0;
      at_pos  <= 5'b00100;
    end else begin
      state   <= state_nxt;
      tgt_idx <= tgt_nxt;
      dwell   <= dwell_nxt;
      pw_cur  <= pw_nxt;
      busy    <= (pw_nxt != pw_tgt_nxt);
      at_pos  <= at_pos_nxt;
    end
  end

endmodule

// File: tb/tb_servo_sequencer.sv
// Self-checking bench for servo_sequencer: frame-level behavioural model plus directed and random scenarios.
`timescale 1ns/1ps
module tb_servo_sequencer;

  localparam int FC     = 1000;
  localparam int PWMIN  = 50;
  localparam int PWSTEP = 100;
  localparam int SLEW   = 40;
  localparam int DWELL  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sel_modo = 1'b0;
  logic [4:0] pos_sel = 5'b00100;
  logic       pwm, frame_tick, busy;
  logic [4:0] at_pos;

  int checks = 0;
  int failures = 0;

  // Frame-level reference model: direction 0 = manual, +1/-1 = sweeping
  int         m_dir, m_idx, m_dwell, m_pw;
  bit         m_busy;
  logic       eff_sel;
  logic [4:0] eff_pos;
  bit         pend;
  logic       pend_sel;
  logic [4:0] pend_pos;
  bit         rec_en = 1'b0;
  int         rec_q[$];

  servo_sequencer #(
    .FRAME_CYCLES(FC), .PW_MIN(PWMIN), .PW_STEP(PWSTEP), .SLEW(SLEW), .DWELL_FRAMES(DWELL)
  ) dut (
    .clk(clk), .reset(reset), .sel_modo(sel_modo), .pos_sel(pos_sel),
    .pwm(pwm), .frame_tick(frame_tick), .busy(busy), .at_pos(at_pos)
  );

  always #5 clk = ~clk;

  function automatic int pw_of(input int idx);
    return PWMIN + (idx - 1) * PWSTEP;
  endfunction

  function automatic logic [4:0] exp_at(input int pw);
    logic [4:0] r;
    r = '0;
    for (int k = 1; k <= 5; k++) if (pw == pw_of(k)) r[k-1] = 1'b1;
    return r;
  endfunction

  function automatic int idx_of(input logic [4:0] v);
    int r;
    r = 0;
    for (int k = 0; k < 5; k++) if (v[k]) r = k + 1;
    return r;
  endfunction

  task automatic model_reset();
    m_dir = 0; m_idx = 3; m_dwell = 0; m_pw = pw_of(3); m_busy = 1'b0; pend = 1'b0;
    eff_sel = 1'b0; eff_pos = 5'b00100;
  endtask

  task automatic model_manual();
    if ($countones(eff_pos) == 1) m_idx = idx_of(eff_pos);
  endtask

  task automatic model_boundary();
    int tgt, d;
    if (m_dir == 0) begin
      if (eff_sel) begin m_dir = (m_idx == 5) ? -1 : 1; m_dwell = 0; end
      else model_manual();
    end else if (!eff_sel) begin
      m_dir = 0; m_dwell = 0; model_manual();
    end else if (!m_busy) begin
      m_dwell++;
      if (m_dwell >= DWELL) begin
        m_dwell = 0;
        if (m_idx + m_dir > 5 || m_idx + m_dir < 1) m_dir = -m_dir;
        m_idx += m_dir;
      end
    end
    tgt = pw_of(m_idx);
    d = tgt - m_pw;
    if (d > SLEW) m_pw += SLEW;
    else if (d < -SLEW) m_pw -= SLEW;
    else m_pw = tgt;
    m_busy = (m_pw != tgt);
    if (pend) begin eff_sel = pend_sel; eff_pos = pend_pos; pend = 1'b0; end
  endtask

  // Runs one frame starting at the negedge of its fcnt=0 cycle; ends at the negedge of the tick cycle
  task automatic run_frame(input int chg, input logic nsel, input logic [4:0] npos,
                           input string tag, output int hi);
    int tick_bad;
    hi = 0; tick_bad = 0;
    for (int i = 0; i < FC; i++) begin
      if (i > 0) @(negedge clk);
      if (i == chg) begin
        sel_modo = nsel; pos_sel = npos;
        if (i <= FC - 3) begin eff_sel = nsel; eff_pos = npos; end
        else begin pend = 1'b1; pend_sel = nsel; pend_pos = npos; end
      end
      if (pwm) hi++;
      if (frame_tick !== 1'(i == FC - 1)) tick_bad++;
      if (i == 0) begin
        checks++;
        if (busy !== m_busy) begin
          failures++; $display("FAIL %s busy: got %0b expected %0b", tag, busy, m_busy);
        end
        checks++;
        if (at_pos !== exp_at(m_pw)) begin
          failures++; $display("FAIL %s at_pos: got %b expected %b", tag, at_pos, exp_at(m_pw));
        end
        if (rec_en && at_pos != 5'b0 && (rec_q.size() == 0 || rec_q[$] != idx_of(at_pos)))
          rec_q.push_back(idx_of(at_pos));
      end
    end
    checks++;
    if (hi != m_pw) begin
      failures++; $display("FAIL %s width: got %0d expected %0d", tag, hi, m_pw);
    end
    checks++;
    if (tick_bad != 0) begin
      failures++; $display("FAIL %s frame_tick: got %0d misplaced cycles expected 0", tag, tick_bad);
    end
  endtask

  task automatic do_frame(input int chg, input logic nsel, input logic [4:0] npos,
                          input string tag, output int hi);
    model_boundary();
    @(negedge clk);
    run_frame(chg, nsel, npos, tag, hi);
  endtask

  task automatic do_reset(input int chg, input logic nsel, input logic [4:0] npos, input string tag);
    int w;
    @(negedge clk);
    reset = 1'b0; sel_modo = 1'b0; pos_sel = 5'b00100;
    repeat (5) @(negedge clk);
    checks++;
    if (pwm !== 1'b0 || frame_tick !== 1'b0 || busy !== 1'b0 || at_pos !== 5'b00100) begin
      failures++;
      $display("FAIL %s reset_outputs: got pwm=%b tick=%b busy=%b at_pos=%b expected 0 0 0 00100",
               tag, pwm, frame_tick, busy, at_pos);
    end
    model_reset();
    reset = 1'b1;
    run_frame(chg, nsel, npos, tag, w);
  endtask

  task automatic test_reset();
    do_reset(-1, 1'b0, 5'b00100, "reset");
  endtask

  task automatic test_center();
    int w;
    do_frame(-1, 1'b0, 5'b00100, "center", w);
    checks++;
    if (w != 250) begin failures++; $display("FAIL center_width: got %0d expected 250", w); end
  endtask

  task automatic test_manual_ramp();
    int w;
    int exp_w[5] = '{290, 330, 370, 410, 450};
    do_frame(10, 1'b0, 5'b10000, "ramp_cmd", w);
    for (int k = 0; k < 5; k++) begin
      do_frame(-1, 1'b0, 5'b10000, "ramp", w);
      checks++;
      if (w != exp_w[k]) begin
        failures++; $display("FAIL ramp_step%0d: got %0d expected %0d", k, w, exp_w[k]);
      end
    end
    checks++;
    if (busy !== 1'b0 || at_pos !== 5'b10000) begin
      failures++; $display("FAIL ramp_settled: got busy=%b at_pos=%b expected 0 10000", busy, at_pos);
    end
  endtask

  task automatic test_invalid_pos();
    int w;
    do_frame(10, 1'b0, 5'b00110, "multi_hot", w);
    do_frame(10, 1'b0, 5'b00000, "multi_hot_hold", w);
    do_frame(-1, 1'b0, 5'b00000, "zero_hold", w);
    checks++;
    if (w != 450 || busy !== 1'b0) begin
      failures++; $display("FAIL invalid_hold: got width=%0d busy=%b expected 450 0", w, busy);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int w;
    model_boundary();
    @(negedge clk);
    repeat (100) @(negedge clk);
    checks++;
    if (pwm !== 1'(99 < m_pw)) begin
      failures++; $display("FAIL mid_pulse_pwm: got %b expected %b", pwm, 1'(99 < m_pw));
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (pwm !== 1'b0 || frame_tick !== 1'b0 || busy !== 1'b0 || at_pos !== 5'b00100) begin
      failures++;
      $display("FAIL mid_reset_outputs: got pwm=%b tick=%b busy=%b at_pos=%b expected 0 0 0 00100",
               pwm, frame_tick, busy, at_pos);
    end
    sel_modo = 1'b0; pos_sel = 5'b00100;
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b1;
    run_frame(-1, 1'b0, 5'b00100, "post_reset", w);
    checks++;
    if (w != 250) begin failures++; $display("FAIL post_reset_width: got %0d expected 250", w); end
  endtask

  task automatic test_sync_latency();
    int w;
    do_frame(FC - 2, 1'b0, 5'b00001, "late_cmd", w);
    do_frame(10, 1'b0, 5'b00100, "late_ignored", w);
    checks++;
    if (w != 250) begin failures++; $display("FAIL late_ignored_width: got %0d expected 250", w); end
    do_frame(FC - 3, 1'b0, 5'b00001, "ontime_cmd", w);
    do_frame(-1, 1'b0, 5'b00001, "ontime_applied", w);
    checks++;
    if (w != 210) begin failures++; $display("FAIL ontime_applied_width: got %0d expected 210", w); end
  endtask

  task automatic test_sweep();
    int w;
    int exp_seq[8] = '{3, 4, 5, 4, 3, 2, 1, 2};
    rec_q.delete();
    rec_en = 1'b1;
    do_reset(5, 1'b1, 5'b00100, "sweep_start");
    for (int f = 0; f < 60 && rec_q.size() < 8; f++) do_frame(-1, 1'b1, 5'b00100, "sweep", w);
    rec_en = 1'b0;
    checks++;
    if (rec_q.size() != 8) begin
      failures++; $display("FAIL sweep_len: got %0d positions expected 8", rec_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rec_q[k] != exp_seq[k]) begin
          failures++; $display("FAIL sweep_pos%0d: got %0d expected %0d", k, rec_q[k], exp_seq[k]);
        end
      end
    end
  endtask

  task automatic test_sweep_abort();
    int w;
    bit found;
    int exp_w[7] = '{290, 250, 210, 170, 130, 90, 50};
    found = 1'b0;
    do_reset(5, 1'b1, 5'b00100, "abort_start");
    for (int f = 0; f < 8 && !found; f++) begin
      model_boundary();
      @(negedge clk);
      if (m_pw == 330 && m_dir != 0) begin
        found = 1'b1;
        run_frame(5, 1'b0, 5'b00001, "abort_cmd", w);
      end else begin
        run_frame(-1, 1'b1, 5'b00100, "abort_sweep", w);
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL abort_reach330: got 0 expected 1"); end
    for (int k = 0; k < 7; k++) begin
      do_frame(-1, 1'b0, 5'b00001, "abort_ramp", w);
      checks++;
      if (w != exp_w[k]) begin
        failures++; $display("FAIL abort_step%0d: got %0d expected %0d", k, w, exp_w[k]);
      end
    end
  endtask

  task automatic test_random();
    int w, chg;
    logic ns;
    logic [4:0] np;
    for (int f = 0; f < 6; f++) begin
      chg = int'($urandom_range(FC - 1, 1));
      ns = ($urandom_range(3, 0) == 0);
      if ($urandom_range(1, 0) == 1) np = 5'(1 << $urandom_range(4, 0));
      else np = 5'($urandom);
      do_frame(chg, ns, np, "random", w);
    end
  endtask

  initial begin
    test_reset();
    test_center();
    test_manual_ramp();
    test_invalid_pos();
    test_reset_mid_pulse();
    test_sync_latency();
    test_sweep();
    test_sweep_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
